picmicro_prog_loader: RTL

PICMICRO_PROG_LOADER -- requirements
Module: picmicro_prog_loader

---
 rtl/picmicro_loader_pkg.sv | 25 ++
 rtl/picmicro_loader_sync_edge.sv | 37 +++
 rtl/picmicro_prog_loader.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/picmicro_loader_pkg.sv
// Shared command codes, FSM states and frame sizes for the PIC serial program loader.
// Readback support is compiled in only when PICMICRO_LOADER_READBACK_EN is defined.
package picmicro_loader_pkg;

  localparam int CMD_BITS   = 6;
  localparam int FRAME_BITS = 16;

  localparam logic [CMD_BITS-1:0] CMD_LOAD_DATA  = 6'h02;
  localparam logic [CMD_BITS-1:0] CMD_READ_DATA  = 6'h04;
  localparam logic [CMD_BITS-1:0] CMD_INC_ADDR   = 6'h06;
  localparam logic [CMD_BITS-1:0] CMD_BEGIN_PROG = 6'h08;
  localparam logic [CMD_BITS-1:0] CMD_RESET_ADDR = 6'h16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_WRITE
`ifdef PICMICRO_LOADER_READBACK_EN
    ,
    ST_READ
`endif
  } loader_state_e;

endpackage

// File: rtl/picmicro_loader_sync_edge.sv
// Brings the asynchronous host pgc/pgd pins into the clk domain and flags pgc rising edges.
module picmicro_loader_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pgc_i,
  input  logic pgd_i,
  output logic pgc_rise_o,
  output logic pgd_bit_o
);

  logic [SYNC_STAGES-1:0] pgc_sync_q;
  logic [SYNC_STAGES-1:0] pgd_sync_q;
  logic                   pgc_prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pgc_sync_q <= '0;
      pgd_sync_q <= '0;
      pgc_prev_q <= 1'b0;
    end else begin
      pgc_sync_q[0] <= pgc_i;
      pgd_sync_q[0] <= pgd_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        pgc_sync_q[i] <= pgc_sync_q[i-1];
        pgd_sync_q[i] <= pgd_sync_q[i-1];
      end
      pgc_prev_q <= pgc_sync_q[SYNC_STAGES-1];
    end
  end

  // Both pins see identical delay, so pgd is sampled in the same cycle the edge is seen.
  assign pgc_rise_o = pgc_sync_q[SYNC_STAGES-1] & ~pgc_prev_q;
  assign pgd_bit_o  = pgd_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/picmicro_prog_loader.sv
// PIC-style serial programming loader: decodes host commands/data frames into memory writes.
// Define PICMICRO_LOADER_READBACK_EN to add the READ_DATA command and pgd readback pins.
module picmicro_prog_loader
  import picmicro_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 13,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  prog_en,
  input  logic                  pgc,
  input  logic                  pgd,
  output logic                  core_hold,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [13:0]           mem_wr_data
`ifdef PICMICRO_LOADER_READBACK_EN
  ,
  input  logic [13:0]           mem_rd_data,
  output logic                  pgd_out,
  output logic                  pgd_oe
`endif
);

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);

  logic pgc_rise;
  logic pgd_bit;

  picmicro_loader_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .pgc_i     (pgc),
    .pgd_i     (pgd),
    .pgc_rise_o(pgc_rise),
    .pgd_bit_o (pgd_bit)
  );

  loader_state_e         state_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [CMD_BITS-1:0]   cmd_sr_q;
  logic [FRAME_BITS-1:0] frame_sr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [13:0]           wr_data_q;
  logic                  wr_en_q;
  logic [CMD_BITS-1:0]   cmd_d;
  logic [FRAME_BITS-1:0] frame_d;

`ifdef PICMICRO_LOADER_READBACK_EN
  logic [FRAME_BITS-1:0] rd_sr_q;
  logic                  pgd_oe_q;
  logic                  pgd_out_q;
`endif

  // LSB-first shifting: each new bit enters at the top and the word slides down.
  assign cmd_d   = {pgd_bit, cmd_sr_q[CMD_BITS-1:1]};
  assign frame_d = {pgd_bit, frame_sr_q[FRAME_BITS-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      cmd_sr_q   <= '0;
      frame_sr_q <= '0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
`ifdef PICMICRO_LOADER_READBACK_EN
      rd_sr_q    <= '0;
      pgd_oe_q   <= 1'b0;
      pgd_out_q  <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      // Dropping prog_en abandons any partial shift; WRITE is left to finish its strobe.
      if (!prog_en && state_q != ST_IDLE && state_q != ST_WRITE) begin
        state_q    <= ST_IDLE;
        bit_cnt_q  <= '0;
        cmd_sr_q   <= '0;
        frame_sr_q <= '0;
`ifdef PICMICRO_LOADER_READBACK_EN
        pgd_oe_q   <= 1'b0;
        pgd_out_q  <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            bit_cnt_q  <= '0;
            cmd_sr_q   <= '0;
            frame_sr_q <= '0;
            if (prog_en) begin
              state_q <= ST_CMD;
              addr_q  <= '0;
            end
          end

          ST_CMD: begin
            if (pgc_rise) begin
              cmd_sr_q <= cmd_d;
              if (bit_cnt_q == CMD_LAST) begin
                bit_cnt_q <= '0;
                case (cmd_d)
                  CMD_LOAD_DATA:  state_q <= ST_DATA;
                  CMD_INC_ADDR:   addr_q  <= addr_q + ADDR_WIDTH'(1);
                  CMD_RESET_ADDR: addr_q  <= '0;
                  CMD_BEGIN_PROG: begin
                    state_q <= ST_WRITE;
                    wr_en_q <= 1'b1;
                  end
`ifdef PICMICRO_LOADER_READBACK_EN
                  CMD_READ_DATA: begin
                    state_q   <= ST_READ;
                    rd_sr_q   <= {1'b0, mem_rd_data, 1'b0};
                    pgd_oe_q  <= 1'b1;
                    pgd_out_q <= 1'b0;
                  end
`endif
                  default: state_q <= ST_CMD;
                endcase
              end else begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              end
            end
          end

          ST_DATA: begin
            if (pgc_rise) begin
              frame_sr_q <= frame_d;
              if (bit_cnt_q == FRAME_LAST) begin
                bit_cnt_q <= '0;
                wr_data_q <= frame_d[14:1];
                state_q   <= ST_CMD;
              end else begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              end
            end
          end

          ST_WRITE: begin
            state_q <= prog_en ? ST_CMD : ST_IDLE;
          end

`ifdef PICMICRO_LOADER_READBACK_EN
          ST_READ: begin
            if (pgc_rise) begin
              if (bit_cnt_q == FRAME_LAST) begin
                bit_cnt_q <= '0;
                pgd_oe_q  <= 1'b0;
                pgd_out_q <= 1'b0;
                state_q   <= ST_CMD;
              end else begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                rd_sr_q   <= rd_sr_q >> 1;
                pgd_out_q <= rd_sr_q[1];
              end
            end
          end
`endif

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign core_hold   = (state_q != ST_IDLE);
  assign mem_wr_en   = wr_en_q;
  assign mem_addr    = addr_q;
  assign mem_wr_data = wr_data_q;

`ifdef PICMICRO_LOADER_READBACK_EN
  assign pgd_oe  = pgd_oe_q;
  assign pgd_out = pgd_out_q;
`endif

endmodule
